sobel_row_window: RTL and testbench
===================================

# sobel_row_window

Three-row sliding-window buffer that sits between input-image memory and the Sobel accelerator core. It consumes one strip-row word per handshake and maintains the row1/row2/row3 window the core convolves. After each consumed window it shifts the rows up by one. It tells the controller when the last window of a strip has been consumed.

## Interface

Parameters:
- `NUM_ACC`, default `` `NUM_SOBEL_ACCELERATORS ``: number of accelerator cores fed.
- `IDATA_W`, default `(NUM_ACC+2)*8`: row word width; must equal `` `SOBEL_IDATA_WIDTH ``.

Ports:
- `clk` in 1: single clock; all logic on the rising edge.
- `reset` in 1: synchronous, active-high.
- `sctl2srow_start` in 1: one-cycle pulse that begins a strip and latches `sctl2srow_num_rows`.
- `sctl2srow_num_rows` in 12: strip height in rows.
- `smem2srow_rdata` in IDATA_W: row word from memory.
- `smem2srow_valid` in 1: `rdata` is valid.
- `srow2smem_ready` out 1: word accepted this cycle when `valid` is also high.
- `srow2sacc_row1_data` / `row2_data` / `row3_data` out IDATA_W each: window; row1 is the oldest.
- `srow2sacc_valid` out 1: window is valid.
- `sacc2srow_ready` in 1: downstream consumes the window.
- `srow2sctl_busy` out 1: high in any state other than IDLE.
- `srow2sctl_done` out 1: one-cycle pulse at end of strip.

## Operation

- States: IDLE, FILL, WINDOW, DONE.
- Registers: `need` (2 bits, words still required before the window is valid), `win_cnt` (12 bits), `num_rows_q` (12 bits).
- **Word accept.** A word is accepted when `srow2smem_ready` and `smem2srow_valid` are both high. On accept: row1<=row2, row2<=row3, row3<=rdata.
- **Window fire.** A window fires when `srow2sacc_valid` and `sacc2srow_ready` are both high.
- **IDLE.**
  - `start` with `num_rows`>=3: `num_rows_q`<=num_rows, `need`<=3, `win_cnt`<=0, go to FILL.
  - `start` with `num_rows`<3: go to DONE; no words are consumed.
- **FILL.**
  - `ready`=1.
  - Each accept decrements `need`.
  - The accept that takes `need` from 1 to 0 moves to WINDOW.
- **WINDOW.**
  - `srow2sacc_valid`=1.
  - `ready` = `sacc2srow_ready` && (`win_cnt` != `num_rows_q`-3).
  - On fire, `win_cnt`++, then:
    - Last window (`win_cnt` == `num_rows_q`-3 before increment): go to DONE.
    - Otherwise, with a simultaneous accept: shift and stay in WINDOW (one window per cycle).
    - Otherwise, no accept: `need`<=1, go to FILL. The rows are left unshifted until the next word arrives.
- **DONE.**
  - `done`=1 for exactly one cycle, then IDLE.
- **Totals.** A strip consumes exactly `num_rows` words and emits `num_rows`-2 windows.
- **Start outside IDLE.** `start` in FILL, WINDOW or DONE aborts the current strip and restarts as if from IDLE. Row registers are not cleared. `done` is not pulsed for the aborted strip.
- **Row data rules.**
  - Row data holds its value whenever no accept occurs.
  - Window data is stable while `valid`=1 and `ready`=0.
- **Reset.** All state returns to IDLE. Row registers, `need`, `win_cnt`, `num_rows_q` are 0. Every output is 0.

## Timing

- All outputs come from registers; there is no combinational path from `smem2srow_valid` to `srow2sacc_valid`.
- `ready` depends combinationally on `sacc2srow_ready` in WINDOW only.
- `start` at edge t: `ready`=1 and `busy`=1 from cycle t+1.
- 3rd word accepted at edge k: `srow2sacc_valid`=1 and the window is visible in cycle k+1.
- Steady state with both sides always ready: one window per cycle.
- Strip of R rows, no stalls: `done` is high R+2 cycles after the `start` cycle (R+3 if the first fire is delayed by `sacc2srow_ready` going high one cycle late).
- Reset asserted mid-strip: outputs are 0 the cycle after the reset edge. An in-flight accept or fire in the reset cycle is discarded.

## Configuration

- Macro `SOBEL_ROW_STALL_CNT_EN`.
- **Defined:** adds output `srow2sctl_stall_cnt` (16 bits).
  - Counts cycles with `srow2sacc_valid`=1 and `sacc2srow_ready`=0.
  - Saturates at 16'hFFFF.
  - Cleared by `reset` and by every `start`.
- **Undefined:** the port and the counter do not exist. All other behaviour is identical.

## Test plan

- **Basic strip.** NUM_ACC=8, `num_rows`=5, words W0..W4 always valid, downstream always ready.
  - Windows (W0,W1,W2), (W1,W2,W3), (W2,W3,W4) on three consecutive cycles.
  - Exactly 5 accepts; `done` pulses once; then IDLE.
- **Downstream stall.** `num_rows`=4; hold `sacc2srow_ready`=0 for 3 cycles on the first window.
  - Window stays (W0,W1,W2) with `valid`=1 and `srow2smem_ready`=0.
  - Stall counter = 3 with `SOBEL_ROW_STALL_CNT_EN` defined.
- **Input bubbles.** `num_rows`=6; `smem2srow_valid` toggles 1,0,1,0.
  - After each fire, `valid` drops until the next word arrives.
  - Window order and content are correct; 4 windows total.
- **Degenerate height.** `num_rows`=2.
  - No accept occurs.
  - `done` is high in cycle t+1 after `start` at edge t.
  - `busy` is high for exactly 1 cycle.
- **Restart and reset.** `start` mid-WINDOW of a 10-row strip with new `num_rows`=3.
  - Next 3 words form one window; one `done`.
  - Then assert `reset` mid-FILL: all outputs 0 next cycle; state IDLE.

Source files
------------

// File: rtl/sobel_row_window_if.sv
// rtl/sobel_row_window_if.sv - handshake bundle between sobel_row_window and its controller, memory and accelerator
//   start/num_rows/busy/done/stall_cnt : strip control
//   rdata/valid/ready (smem side)       : incoming row words
//   row1/row2/row3/valid/ready (sacc)   : outgoing window
//   master = the row-window block, slave = the surrounding system
//   optional stall_cnt port: SOBEL_ROW_STALL_CNT_EN
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 8
`endif
`ifndef SOBEL_IDATA_WIDTH
`define SOBEL_IDATA_WIDTH ((`NUM_SOBEL_ACCELERATORS+2)*8)
`endif

interface sobel_row_window_if #(
  parameter int IDATA_W = `SOBEL_IDATA_WIDTH
);
  logic               sctl2srow_start;
  logic [11:0]        sctl2srow_num_rows;
  logic [IDATA_W-1:0] smem2srow_rdata;
  logic               smem2srow_valid;
  logic               srow2smem_ready;
  logic [IDATA_W-1:0] srow2sacc_row1_data;
  logic [IDATA_W-1:0] srow2sacc_row2_data;
  logic [IDATA_W-1:0] srow2sacc_row3_data;
  logic               srow2sacc_valid;
  logic               sacc2srow_ready;
  logic               srow2sctl_busy;
  logic               srow2sctl_done;
`ifdef SOBEL_ROW_STALL_CNT_EN
  logic [15:0]        srow2sctl_stall_cnt;

  modport master (
    input  sctl2srow_start, sctl2srow_num_rows, smem2srow_rdata, smem2srow_valid, sacc2srow_ready,
    output srow2smem_ready, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data,
           srow2sacc_valid, srow2sctl_busy, srow2sctl_done, srow2sctl_stall_cnt
  );
  modport slave (
    output sctl2srow_start, sctl2srow_num_rows, smem2srow_rdata, smem2srow_valid, sacc2srow_ready,
    input  srow2smem_ready, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data,
           srow2sacc_valid, srow2sctl_busy, srow2sctl_done, srow2sctl_stall_cnt
  );
`else
  modport master (
    input  sctl2srow_start, sctl2srow_num_rows, smem2srow_rdata, smem2srow_valid, sacc2srow_ready,
    output srow2smem_ready, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data,
           srow2sacc_valid, srow2sctl_busy, srow2sctl_done
  );
  modport slave (
    output sctl2srow_start, sctl2srow_num_rows, smem2srow_rdata, smem2srow_valid, sacc2srow_ready,
    input  srow2smem_ready, srow2sacc_row1_data, srow2sacc_row2_data, srow2sacc_row3_data,
           srow2sacc_valid, srow2sctl_busy, srow2sctl_done
  );
`endif
endinterface

// File: rtl/sobel_row_window.sv
// rtl/sobel_row_window.sv - three-row sliding window feeding the Sobel accelerator core
//   clk   : rising-edge clock
//   reset : synchronous, active-high
//   bus   : sobel_row_window_if.master (control, memory words in, window out)
//   optional stall counter: SOBEL_ROW_STALL_CNT_EN
`ifndef NUM_SOBEL_ACCELERATORS
`define NUM_SOBEL_ACCELERATORS 8
`endif

module sobel_row_window #(
  parameter int NUM_ACC = `NUM_SOBEL_ACCELERATORS,
  parameter int IDATA_W = (NUM_ACC+2)*8
) (
  input  logic               clk,
  input  logic               reset,
  sobel_row_window_if.master bus
);
  typedef enum logic [1:0] {IDLE, FILL, WINDOW, DONE} state_t;

  state_t             state_q, state_d;
  logic [1:0]         need_q, need_d;
  logic [11:0]        win_cnt_q, win_cnt_d;
  logic [11:0]        num_rows_q, num_rows_d;
  logic [IDATA_W-1:0] row1_q, row2_q, row3_q;
  logic               ready, valid, accept, fire, last_win;

  assign valid    = (state_q == WINDOW);
  assign last_win = (win_cnt_q == num_rows_q - 12'd3);
  assign accept   = ready && bus.smem2srow_valid;
  assign fire     = valid && bus.sacc2srow_ready;

  // In WINDOW a new word may only enter if the current window leaves in the
  // same cycle; the last window takes no word because the strip is exhausted.
  always_comb begin
    ready = 1'b0;
    case (state_q)
      FILL:    ready = 1'b1;
      WINDOW:  ready = bus.sacc2srow_ready && !last_win;
      default: ready = 1'b0;
    endcase
  end

  always_comb begin
    state_d    = state_q;
    need_d     = need_q;
    win_cnt_d  = win_cnt_q;
    num_rows_d = num_rows_q;
    if (bus.sctl2srow_start) begin
      // start wins in every state, aborting any strip in progress
      if (bus.sctl2srow_num_rows >= 12'd3) begin
        num_rows_d = bus.sctl2srow_num_rows;
        need_d     = 2'd3;
        win_cnt_d  = 12'd0;
        state_d    = FILL;
      end else begin
        state_d = DONE;
      end
    end else begin
      case (state_q)
        IDLE: state_d = IDLE;
        FILL: begin
          if (accept) begin
            need_d = need_q - 2'd1;
            if (need_q == 2'd1) state_d = WINDOW;
          end
        end
        WINDOW: begin
          if (fire) begin
            win_cnt_d = win_cnt_q + 12'd1;
            if (last_win) begin
              state_d = DONE;
            end else if (!accept) begin
              // rows stay unshifted until the missing word arrives
              need_d  = 2'd1;
              state_d = FILL;
            end
          end
        end
        DONE:    state_d = IDLE;
        default: state_d = IDLE;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q    <= IDLE;
      need_q     <= 2'd0;
      win_cnt_q  <= 12'd0;
      num_rows_q <= 12'd0;
      row1_q     <= '0;
      row2_q     <= '0;
      row3_q     <= '0;
    end else begin
      state_q    <= state_d;
      need_q     <= need_d;
      win_cnt_q  <= win_cnt_d;
      num_rows_q <= num_rows_d;
      if (accept) begin
        row1_q <= row2_q;
        row2_q <= row3_q;
        row3_q <= bus.smem2srow_rdata;
      end
    end
  end

  assign bus.srow2smem_ready     = ready;
  assign bus.srow2sacc_valid     = valid;
  assign bus.srow2sacc_row1_data = row1_q;
  assign bus.srow2sacc_row2_data = row2_q;
  assign bus.srow2sacc_row3_data = row3_q;
  assign bus.srow2sctl_busy      = (state_q != IDLE);
  assign bus.srow2sctl_done      = (state_q == DONE);

`ifdef SOBEL_ROW_STALL_CNT_EN
  logic [15:0] stall_cnt_q;

  always_ff @(posedge clk) begin
    if (reset || bus.sctl2srow_start) begin
      stall_cnt_q <= 16'd0;
    end else if (valid && !bus.sacc2srow_ready && stall_cnt_q != 16'hFFFF) begin
      stall_cnt_q <= stall_cnt_q + 16'd1;
    end
  end

  assign bus.srow2sctl_stall_cnt = stall_cnt_q;
`endif
endmodule

// File: tb/tb_sobel_row_window.sv
// tb/tb_sobel_row_window.sv - randomized self-checking bench for sobel_row_window
module tb_sobel_row_window;
  localparam int NA = 8;
  localparam int IW = (NA+2)*8;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  sobel_row_window_if #(.IDATA_W(IW)) bus ();

  sobel_row_window #(.NUM_ACC(NA), .IDATA_W(IW)) dut (
    .clk   (clk),
    .reset (reset),
    .bus   (bus)
  );

  int total = 0;
  int bad   = 0;

  logic [IW-1:0]   src[$];
  logic [3*IW-1:0] obs[$];
  int accepts, fires, dones, unstable, refill_bad, hold_ready;
  int done_cyc, first_valid_cyc, busy_cycles;
  bit timed_out;
  logic post_busy, post_done;

  function automatic logic [IW-1:0] rand_word();
    logic [95:0] t;
    t = {$urandom, $urandom, $urandom};
    return t[IW-1:0];
  endfunction

  // Model: a strip of words w0..w(R-1) yields windows (wi, wi+1, wi+2), oldest first.
  function automatic int win_errors(input int rows);
    int n, e;
    logic [3*IW-1:0] exp_w;
    n = (rows >= 3) ? rows - 2 : 0;
    e = (obs.size() > n) ? obs.size() - n : n - obs.size();
    for (int i = 0; i < n && i < obs.size(); i++) begin
      exp_w = {src[i], src[i+1], src[i+2]};
      if (obs[i] !== exp_w) e++;
    end
    return e;
  endfunction

  task automatic run_strip(input int rows, input int vpct, input int rpct,
                           input int stall_first, input bit toggle, input int budget);
    int idx, cyc, stall_left, nexp;
    bit fin, prev_hold, prev_refill, phase, acc, fr;
    logic [3*IW-1:0] prev_win, cur_win;
    src.delete();
    obs.delete();
    for (int i = 0; i < rows; i++) src.push_back(rand_word());
    accepts = 0; fires = 0; dones = 0; unstable = 0; refill_bad = 0; hold_ready = 0;
    done_cyc = -1; first_valid_cyc = -1; busy_cycles = 0; timed_out = 0;
    nexp = (rows >= 3) ? rows - 2 : 0;
    @(negedge clk);
    bus.sctl2srow_start    = 1'b1;
    bus.sctl2srow_num_rows = 12'(rows);
    bus.smem2srow_valid    = 1'b0;
    bus.sacc2srow_ready    = 1'b0;
    @(negedge clk);
    bus.sctl2srow_start = 1'b0;
    idx = 0; cyc = 1; fin = 0; prev_hold = 0; prev_refill = 0; phase = 1;
    stall_left = stall_first; prev_win = '0;
    while (!fin && cyc < budget) begin
      bus.smem2srow_valid = (idx < rows) && (toggle ? phase : (int'($urandom_range(0, 99)) < vpct));
      if (idx < rows) bus.smem2srow_rdata = src[idx];
      else            bus.smem2srow_rdata = '0;
      phase = !phase;
      #1;
      if (stall_left > 0 && bus.srow2sacc_valid) begin
        bus.sacc2srow_ready = 1'b0;
        stall_left--;
      end else begin
        bus.sacc2srow_ready = int'($urandom_range(0, 99)) < rpct;
      end
      #1;
      cur_win = {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data};
      if (bus.srow2sctl_busy) busy_cycles++;
      if (prev_hold && cur_win !== prev_win) unstable++;
      if (prev_refill && bus.srow2sacc_valid) refill_bad++;
      if (bus.srow2sacc_valid && first_valid_cyc < 0) first_valid_cyc = cyc;
      if (bus.srow2sctl_done) begin
        dones++;
        done_cyc = cyc;
        fin = 1;
      end
      acc = bus.srow2smem_ready && bus.smem2srow_valid;
      fr  = bus.srow2sacc_valid && bus.sacc2srow_ready;
      if (acc) begin accepts++; idx++; end
      if (fr) begin obs.push_back(cur_win); fires++; end
      if (bus.srow2sacc_valid && !bus.sacc2srow_ready && bus.srow2smem_ready) hold_ready++;
      prev_hold   = bus.srow2sacc_valid && !bus.sacc2srow_ready;
      prev_refill = fr && !acc && (fires != nexp);
      prev_win    = cur_win;
      @(negedge clk);
      cyc++;
    end
    bus.smem2srow_valid = 1'b0;
    bus.sacc2srow_ready = 1'b0;
    #1;
    post_busy = bus.srow2sctl_busy;
    post_done = bus.srow2sctl_done;
    if (!fin) timed_out = 1;
  endtask

  task automatic test_reset;
    bus.sctl2srow_start = 0; bus.sctl2srow_num_rows = 0; bus.smem2srow_rdata = '0;
    bus.smem2srow_valid = 0; bus.sacc2srow_ready = 0;
    reset = 1'b1;
    @(negedge clk); @(negedge clk); #1;
    total++; if (bus.srow2smem_ready !== 1'b0) begin bad++; $display("FAIL reset_ready got=%0b exp=0", bus.srow2smem_ready); end
    total++; if (bus.srow2sacc_valid !== 1'b0) begin bad++; $display("FAIL reset_valid got=%0b exp=0", bus.srow2sacc_valid); end
    total++; if (bus.srow2sctl_busy !== 1'b0) begin bad++; $display("FAIL reset_busy got=%0b exp=0", bus.srow2sctl_busy); end
    total++; if (bus.srow2sctl_done !== 1'b0) begin bad++; $display("FAIL reset_done got=%0b exp=0", bus.srow2sctl_done); end
    total++; if ({bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data} !== '0) begin
      bad++; $display("FAIL reset_rows got=%h exp=0", {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data});
    end
`ifdef SOBEL_ROW_STALL_CNT_EN
    total++; if (bus.srow2sctl_stall_cnt !== 16'd0) begin bad++; $display("FAIL reset_stall_cnt got=%0d exp=0", bus.srow2sctl_stall_cnt); end
`endif
    reset = 1'b0;
    @(negedge clk); #1;
    total++; if (bus.srow2sctl_busy !== 1'b0) begin bad++; $display("FAIL idle_busy got=%0b exp=0", bus.srow2sctl_busy); end
  endtask

  task automatic test_basic_strip;
    run_strip(5, 100, 100, 0, 0, 40);
    total++; if (timed_out) begin bad++; $display("FAIL basic_timeout got=1 exp=0"); end
    total++; if (accepts !== 5) begin bad++; $display("FAIL basic_accepts got=%0d exp=5", accepts); end
    total++; if (fires !== 3) begin bad++; $display("FAIL basic_fires got=%0d exp=3", fires); end
    total++; if (win_errors(5) !== 0) begin bad++; $display("FAIL basic_windows got=%0d errors exp=0", win_errors(5)); end
    total++; if (first_valid_cyc !== 4) begin bad++; $display("FAIL basic_first_valid got=%0d exp=4", first_valid_cyc); end
    total++; if (done_cyc !== 7) begin bad++; $display("FAIL basic_done_cycle got=%0d exp=7", done_cyc); end
    total++; if (dones !== 1 || post_done !== 1'b0) begin bad++; $display("FAIL basic_done_once got=%0d/%0b exp=1/0", dones, post_done); end
    total++; if (post_busy !== 1'b0) begin bad++; $display("FAIL basic_idle got=%0b exp=0", post_busy); end
  endtask

  task automatic test_stall;
    run_strip(4, 100, 100, 3, 0, 40);
    total++; if (win_errors(4) !== 0) begin bad++; $display("FAIL stall_windows got=%0d errors exp=0", win_errors(4)); end
    total++; if (unstable !== 0) begin bad++; $display("FAIL stall_stable got=%0d changes exp=0", unstable); end
    total++; if (hold_ready !== 0) begin bad++; $display("FAIL stall_mem_ready got=%0d exp=0", hold_ready); end
    total++; if (done_cyc !== 9) begin bad++; $display("FAIL stall_done_cycle got=%0d exp=9", done_cyc); end
`ifdef SOBEL_ROW_STALL_CNT_EN
    total++; if (bus.srow2sctl_stall_cnt !== 16'd3) begin bad++; $display("FAIL stall_cnt got=%0d exp=3", bus.srow2sctl_stall_cnt); end
`endif
  endtask

  task automatic test_bubbles;
    run_strip(6, 0, 100, 0, 1, 60);
    total++; if (fires !== 4) begin bad++; $display("FAIL bubble_fires got=%0d exp=4", fires); end
    total++; if (win_errors(6) !== 0) begin bad++; $display("FAIL bubble_windows got=%0d errors exp=0", win_errors(6)); end
    total++; if (refill_bad !== 0) begin bad++; $display("FAIL bubble_valid_drop got=%0d exp=0", refill_bad); end
    total++; if (accepts !== 6) begin bad++; $display("FAIL bubble_accepts got=%0d exp=6", accepts); end
  endtask

  task automatic test_degenerate;
    run_strip(2, 100, 100, 0, 0, 20);
    total++; if (accepts !== 0) begin bad++; $display("FAIL degen_accepts got=%0d exp=0", accepts); end
    total++; if (done_cyc !== 1) begin bad++; $display("FAIL degen_done_cycle got=%0d exp=1", done_cyc); end
    total++; if (busy_cycles !== 1) begin bad++; $display("FAIL degen_busy got=%0d exp=1", busy_cycles); end
    total++; if (post_busy !== 1'b0) begin bad++; $display("FAIL degen_idle got=%0b exp=0", post_busy); end
  endtask

  task automatic test_restart_reset;
    int acc, saw_done;
    @(negedge clk);
    bus.sctl2srow_start = 1; bus.sctl2srow_num_rows = 12'd10;
    bus.smem2srow_valid = 0; bus.sacc2srow_ready = 0;
    @(negedge clk);
    bus.sctl2srow_start = 0;
    acc = 0; saw_done = 0;
    for (int c = 0; c < 10 && !bus.srow2sacc_valid; c++) begin
      bus.smem2srow_valid = 1; bus.smem2srow_rdata = rand_word();
      #1;
      if (bus.srow2smem_ready) acc++;
      if (bus.srow2sctl_done) saw_done++;
      @(negedge clk);
    end
    bus.smem2srow_valid = 0;
    #1;
    total++; if (bus.srow2sacc_valid !== 1'b1 || acc !== 3) begin bad++; $display("FAIL abort_setup got=%0b/%0d exp=1/3", bus.srow2sacc_valid, acc); end
    run_strip(3, 100, 100, 0, 0, 40);
    total++; if (accepts !== 3 || fires !== 1) begin bad++; $display("FAIL restart_counts got=%0d/%0d exp=3/1", accepts, fires); end
    total++; if (win_errors(3) !== 0) begin bad++; $display("FAIL restart_window got=%0d errors exp=0", win_errors(3)); end
    total++; if (dones + saw_done !== 1 || done_cyc !== 5) begin bad++; $display("FAIL restart_done got=%0d@%0d exp=1@5", dones + saw_done, done_cyc); end
    // reset while filling, with an accept pending at the reset edge
    @(negedge clk);
    bus.sctl2srow_start = 1; bus.sctl2srow_num_rows = 12'd8;
    @(negedge clk);
    bus.sctl2srow_start = 0; bus.smem2srow_valid = 1; bus.smem2srow_rdata = rand_word();
    @(negedge clk);
    bus.smem2srow_rdata = rand_word(); reset = 1;
    @(negedge clk);
    reset = 0; bus.smem2srow_valid = 0;
    #1;
    total++; if ({bus.srow2smem_ready, bus.srow2sacc_valid, bus.srow2sctl_busy, bus.srow2sctl_done} !== 4'b0) begin
      bad++; $display("FAIL midreset_ctrl got=%b exp=0000", {bus.srow2smem_ready, bus.srow2sacc_valid, bus.srow2sctl_busy, bus.srow2sctl_done});
    end
    total++; if ({bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data} !== '0) begin
      bad++; $display("FAIL midreset_rows got=%h exp=0", {bus.srow2sacc_row1_data, bus.srow2sacc_row2_data, bus.srow2sacc_row3_data});
    end
  endtask

  task automatic test_random;
    int rows, nexp;
    for (int s = 0; s < 12; s++) begin
      rows = $urandom_range(0, 12);
      nexp = (rows >= 3) ? rows - 2 : 0;
      run_strip(rows, $urandom_range(30, 100), $urandom_range(30, 100), 0, 0, 400);
      total++; if (timed_out) begin bad++; $display("FAIL rand%0d_timeout rows=%0d got=1 exp=0", s, rows); end
      total++; if (accepts !== ((rows >= 3) ? rows : 0)) begin bad++; $display("FAIL rand%0d_accepts got=%0d exp=%0d", s, accepts, (rows >= 3) ? rows : 0); end
      total++; if (fires !== nexp) begin bad++; $display("FAIL rand%0d_fires got=%0d exp=%0d", s, fires, nexp); end
      total++; if (win_errors(rows) !== 0) begin bad++; $display("FAIL rand%0d_windows got=%0d errors exp=0", s, win_errors(rows)); end
      total++; if (unstable !== 0 || refill_bad !== 0) begin bad++; $display("FAIL rand%0d_rules got=%0d/%0d exp=0/0", s, unstable, refill_bad); end
      total++; if (dones !== 1 || post_busy !== 1'b0) begin bad++; $display("FAIL rand%0d_end got=%0d/%0b exp=1/0", s, dones, post_busy); end
    end
  endtask

  initial begin
    test_reset();
    test_basic_strip();
    test_stall();
    test_bubbles();
    test_degenerate();
    test_restart_reset();
    test_random();
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
